// File: rtl/vga_rx_decoder_pkg.sv
// Shared 640x480 timing defaults, decoder FSM states and signature step.
// Latency: n/a (package). Backpressure: n/a.
package vga_rx_decoder_pkg;

    localparam int       VGA_H_DISPLAY   = 640;
    localparam int       VGA_H_BACK      = 48;
    localparam int       VGA_H_SYNC      = 96;
    localparam int       VGA_H_TOTAL     = 800;
    localparam int       VGA_V_DISPLAY   = 480;
    localparam int       VGA_V_BACK      = 33;
    localparam int       VGA_V_SYNC      = 2;
    localparam int       VGA_V_TOTAL     = 525;
    localparam logic     VGA_SYNC_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    // Rotate-left by one, then fold in the 12-bit pixel.
    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [11:0] c);
        return {s[14:0], s[15]} ^ {4'h0, c};
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync sampler: keeps the last p_tick sample and flags the assertion edge.
// Latency: edge is combinational on the sampling tick. Backpressure: none.
module vga_sync_edge #(
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_edge
);

    logic r_level;

    // Resetting to the active level means a stream already inside its sync
    // pulse at reset release does not produce a spurious edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= SYNC_ACTIVE;
        end else if (i_tick) begin
            r_level <= i_sync;
        end
    end

    assign o_edge = i_tick && (i_sync == SYNC_ACTIVE) && (r_level != SYNC_ACTIVE);

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: locks to sync timing, emits per-pixel x/y/rgb and a per-frame signature.
// Latency: outputs registered, one clk after the p_tick sample. Backpressure: none (stream sink).
// Optional VGA_RX_ERRCNT_EN adds a saturating err_count[7:0] output.
module vga_rx_decoder
    import vga_rx_decoder_pkg::*;
#(
    parameter int   H_DISPLAY   = VGA_H_DISPLAY,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_TOTAL     = VGA_H_TOTAL,
    parameter int   V_DISPLAY   = VGA_V_DISPLAY,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_TOTAL     = VGA_V_TOTAL,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sig,
    output logic        timing_err
`ifdef VGA_RX_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_H_ACT0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] L_H_ACT1 = 10'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] L_V_ACT1 = 10'(V_SYNC + V_BACK + V_DISPLAY);

    rx_state_t   r_state, w_state_nxt;
    logic [9:0]  r_hpos, r_vline, w_hpos_nxt, w_vline_nxt;
    logic [15:0] r_sig, w_sig_nxt, r_frame_sig;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [11:0] r_pix_rgb;
    logic        r_pix_valid, r_frame_done, r_timing_err;
    logic        w_hedge, w_vedge, w_err, w_chk, w_active, w_pix, w_frame_done;

    vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_hsync_edge (
        .i_clk   (clk_100MHz),
        .i_rst_n (reset),
        .i_tick  (p_tick),
        .i_sync  (hsync),
        .o_edge  (w_hedge)
    );

    vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_vsync_edge (
        .i_clk   (clk_100MHz),
        .i_rst_n (reset),
        .i_tick  (p_tick),
        .i_sync  (vsync),
        .o_edge  (w_vedge)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_hpos_nxt   = r_hpos;
        w_vline_nxt  = r_vline;
        w_sig_nxt    = r_sig;
        w_err        = 1'b0;
        w_chk        = 1'b0;
        w_active     = 1'b0;
        w_pix        = 1'b0;
        w_frame_done = 1'b0;
        if (p_tick) begin
            // hpos holds at the last position so a missing hsync stays visible.
            if (w_hedge)                 w_hpos_nxt = '0;
            else if (r_hpos != L_H_LAST) w_hpos_nxt = r_hpos + 10'd1;
            if (w_vedge)                 w_vline_nxt = '0;
            else if (w_hedge)            w_vline_nxt = r_vline + 10'd1;

            w_active = (w_hpos_nxt >= L_H_ACT0) && (w_hpos_nxt < L_H_ACT1) &&
                       (w_vline_nxt >= L_V_ACT0) && (w_vline_nxt < L_V_ACT1);

            w_chk = (r_state == ST_ALIGN) || (r_state == ST_LOCKED);
            if (w_chk) begin
                if (w_hedge && (r_hpos != L_H_LAST))   w_err = 1'b1;
                if (!w_hedge && (r_hpos == L_H_LAST))  w_err = 1'b1;
                if (w_vedge && (r_vline != L_V_LAST))  w_err = 1'b1;
            end

            case (r_state)
                ST_SEARCH: begin
                    if (w_vedge) w_state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (w_err) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_vedge) begin
                        w_state_nxt = ST_LOCKED;
                        w_sig_nxt   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_err) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_vedge) begin
                        w_frame_done = 1'b1;
                        w_sig_nxt    = '0;
                    end else if (w_active) begin
                        w_pix     = 1'b1;
                        w_sig_nxt = sig_step(r_sig, rgb);
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SEARCH;
            r_hpos       <= '0;
            r_vline      <= '0;
            r_sig        <= '0;
            r_frame_sig  <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_rgb    <= '0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_timing_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hpos       <= w_hpos_nxt;
            r_vline      <= w_vline_nxt;
            r_sig        <= w_sig_nxt;
            r_pix_valid  <= w_pix;
            r_frame_done <= w_frame_done;
            r_timing_err <= w_err;
            if (w_pix) begin
                r_pix_x   <= w_hpos_nxt - L_H_ACT0;
                r_pix_y   <= w_vline_nxt - L_V_ACT0;
                r_pix_rgb <= rgb;
            end
            if (w_frame_done) r_frame_sig <= r_sig;
        end
    end

`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_rgb    = r_pix_rgb;
    assign locked     = (r_state == ST_LOCKED);
    assign frame_done = r_frame_done;
    assign frame_sig  = r_frame_sig;
    assign timing_err = r_timing_err;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a shrunken 16x9 raster; pixel and signature scoreboards.
module tb_vga_rx_decoder;

    localparam int   TH_DISPLAY = 8;
    localparam int   TH_BACK    = 3;
    localparam int   TH_SYNC    = 2;
    localparam int   TH_TOTAL   = 16;
    localparam int   TV_DISPLAY = 4;
    localparam int   TV_BACK    = 2;
    localparam int   TV_SYNC    = 1;
    localparam int   TV_TOTAL   = 9;
    localparam logic ACT        = 1'b0;
    localparam int   PIX_FRAME  = TH_DISPLAY * TV_DISPLAY;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    logic        clk;
    logic        reset;
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sig;
    logic        timing_err;
`ifdef VGA_RX_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    pix_t        pix_q[$];
    logic [15:0] sig_q[$];
    logic [15:0] model_sig;
    int          checks;
    int          errors;
    int          tick_no;
    int          n_pix;
    int          n_done;
    int          n_terr;
    int          last_terr_tick;
    int          exp_err_tick;
    logic [9:0]  last_x;
    logic [9:0]  last_y;

    vga_rx_decoder #(
        .H_DISPLAY (TH_DISPLAY), .H_BACK (TH_BACK), .H_SYNC (TH_SYNC), .H_TOTAL (TH_TOTAL),
        .V_DISPLAY (TV_DISPLAY), .V_BACK (TV_BACK), .V_SYNC (TV_SYNC), .V_TOTAL (TV_TOTAL),
        .SYNC_ACTIVE (ACT)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_sig  (frame_sig),
        .timing_err (timing_err)
`ifdef VGA_RX_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    // Output monitor: pops the scoreboards whenever the DUT reports.
    always @(negedge clk) begin
        pix_t e;
        logic [15:0] es;
        if (pix_valid) begin
            n_pix++;
            last_x = pix_x;
            last_y = pix_y;
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h, required no pixel", pix_x, pix_y, pix_rgb);
            end else begin
                e = pix_q.pop_front();
                if ({pix_x, pix_y, pix_rgb} !== {e.x, e.y, e.rgb}) begin
                    errors++;
                    $display("FAIL pix_data: got x=%0d y=%0d rgb=%h, required x=%0d y=%0d rgb=%h",
                             pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
                end
            end
        end
        if (frame_done) begin
            n_done++;
            checks++;
            if (sig_q.size() == 0) begin
                errors++;
                $display("FAIL frame_done_unexpected: got frame_sig=%h, required no frame_done", frame_sig);
            end else begin
                es = sig_q.pop_front();
                if (frame_sig !== es) begin
                    errors++;
                    $display("FAIL frame_sig: got %h, required %h", frame_sig, es);
                end
            end
        end
        if (timing_err) begin
            n_terr++;
            last_terr_tick = tick_no;
        end
    end

    task automatic drive_tick(input logic h, input logic v, input logic [11:0] c);
        tick_no++;
        hsync  = h;
        vsync  = v;
        rgb    = c;
        p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_line(input int vl, input int h0, input int len, input bit pix_exp,
                             input bit solid, input logic [11:0] col);
        logic [11:0] c;
        logic        hs;
        logic        vs;
        pix_t        e;
        for (int h = h0; h < len; h++) begin
            c  = solid ? col : 12'(h * 37 + vl * 101 + 5);
            hs = (h < TH_SYNC) ? ACT : ~ACT;
            vs = (vl < TV_SYNC) ? ACT : ~ACT;
            if (pix_exp && h >= TH_SYNC + TH_BACK && h < TH_SYNC + TH_BACK + TH_DISPLAY &&
                vl >= TV_SYNC + TV_BACK && vl < TV_SYNC + TV_BACK + TV_DISPLAY) begin
                e.x   = 10'(h - (TH_SYNC + TH_BACK));
                e.y   = 10'(vl - (TV_SYNC + TV_BACK));
                e.rgb = c;
                pix_q.push_back(e);
                model_sig = {model_sig[14:0], model_sig[15]} ^ {4'h0, c};
            end
            drive_tick(hs, vs, c);
        end
    endtask

    // short_vl >= 0 makes that line one tick short; pixels after it are not expected.
    task automatic send_frame(input bit pix_exp, input bit done_exp, input bit solid,
                              input logic [11:0] col, input int short_vl, input int n_lines);
        if (done_exp) sig_q.push_back(model_sig);
        model_sig = 16'h0;
        for (int vl = 0; vl < n_lines; vl++) begin
            if (short_vl >= 0 && vl == short_vl + 1) exp_err_tick = tick_no + 1;
            send_line(vl, 0, (vl == short_vl) ? TH_TOTAL - 1 : TH_TOTAL,
                      pix_exp && (short_vl < 0 || vl <= short_vl), solid, col);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        send_line(4, 0, 3, 1'b0, 1'b0, 12'h0);
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb} !== 33'h0) begin
            errors++;
            $display("FAIL reset_pix: got %h, required 0", {pix_valid, pix_x, pix_y, pix_rgb});
        end
        checks++;
        if ({locked, frame_done, frame_sig, timing_err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_ctl: got %h, required 0", {locked, frame_done, frame_sig, timing_err});
        end
`ifdef VGA_RX_ERRCNT_EN
        checks++;
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_errcnt: got %h, required 00", err_count);
        end
`endif
        reset = 1'b1;
        send_line(4, 3, TH_TOTAL, 1'b0, 1'b0, 12'h0);
        for (int vl = 5; vl < TV_TOTAL; vl++) send_line(vl, 0, TH_TOTAL, 1'b0, 1'b0, 12'h0);
        checks++;
        if (locked !== 1'b0 || n_pix !== 0) begin
            errors++;
            $display("FAIL search_after_reset: got locked=%b pixels=%0d, required locked=0 pixels=0", locked, n_pix);
        end
        send_frame(1'b0, 1'b0, 1'b0, 12'h0, -1, TV_TOTAL);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL locked_after_one_edge: got %b, required 0", locked);
        end
    endtask

    task automatic test_lock_pixels();
        int p0;
        p0 = n_pix;
        send_frame(1'b1, 1'b0, 1'b0, 12'h0, -1, TV_TOTAL);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL locked_after_two_edges: got %b, required 1", locked);
        end
        checks++;
        if (n_pix - p0 !== PIX_FRAME) begin
            errors++;
            $display("FAIL pix_count: got %0d, required %0d", n_pix - p0, PIX_FRAME);
        end
        checks++;
        if (last_x !== 10'(TH_DISPLAY - 1) || last_y !== 10'(TV_DISPLAY - 1)) begin
            errors++;
            $display("FAIL last_pixel: got x=%0d y=%0d, required x=%0d y=%0d", last_x, last_y, TH_DISPLAY - 1, TV_DISPLAY - 1);
        end
    endtask

    task automatic test_signature();
        logic [15:0] golden;
        int d0;
        golden = 16'h0;
        for (int i = 0; i < PIX_FRAME; i++) golden = {golden[14:0], golden[15]} ^ 16'h0F00;
        d0 = n_done;
        send_frame(1'b1, 1'b1, 1'b1, 12'hF00, -1, TV_TOTAL);
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL done_count_a: got %0d, required 1", n_done - d0);
        end
        send_frame(1'b1, 1'b1, 1'b0, 12'h0, -1, TV_TOTAL);
        checks++;
        if (n_done - d0 !== 2) begin
            errors++;
            $display("FAIL done_count_b: got %0d, required 2", n_done - d0);
        end
        checks++;
        if (frame_sig !== golden) begin
            errors++;
            $display("FAIL solid_sig: got %h, required %h", frame_sig, golden);
        end
    endtask

    task automatic test_short_line();
        int t0;
        int p0;
        int p1;
        t0 = n_terr;
        p0 = n_pix;
        send_frame(1'b1, 1'b1, 1'b0, 12'h0, 4, TV_TOTAL);
        checks++;
        if (n_terr - t0 !== 1 || last_terr_tick !== exp_err_tick) begin
            errors++;
            $display("FAIL short_line_err: got %0d pulses at tick %0d, required 1 at tick %0d", n_terr - t0, last_terr_tick, exp_err_tick);
        end
        checks++;
        if (locked !== 1'b0 || n_pix - p0 !== 2 * TH_DISPLAY) begin
            errors++;
            $display("FAIL short_line_unlock: got locked=%b pixels=%0d, required locked=0 pixels=%0d", locked, n_pix - p0, 2 * TH_DISPLAY);
        end
        p1 = n_pix;
        send_frame(1'b0, 1'b0, 1'b0, 12'h0, -1, TV_TOTAL);
        checks++;
        if (locked !== 1'b0 || n_pix !== p1 || n_terr - t0 !== 1) begin
            errors++;
            $display("FAIL realign: got locked=%b pixels=%0d errs=%0d, required locked=0 pixels=0 errs=1", locked, n_pix - p1, n_terr - t0);
        end
        send_frame(1'b1, 1'b0, 1'b0, 12'h0, -1, TV_TOTAL);
        checks++;
        if (locked !== 1'b1 || n_pix - p1 !== PIX_FRAME) begin
            errors++;
            $display("FAIL relock: got locked=%b pixels=%0d, required locked=1 pixels=%0d", locked, n_pix - p1, PIX_FRAME);
        end
    endtask

    task automatic test_missing_hsync();
        int t0;
        int exp_tick;
        t0 = n_terr;
        send_frame(1'b0, 1'b1, 1'b0, 12'h0, -1, 1);
        exp_tick = tick_no + 1;
        for (int k = 0; k < 30; k++) drive_tick(~ACT, ~ACT, 12'h0);
        checks++;
        if (n_terr - t0 !== 1 || last_terr_tick !== exp_tick) begin
            errors++;
            $display("FAIL missing_hsync_err: got %0d pulses at tick %0d, required 1 at tick %0d", n_terr - t0, last_terr_tick, exp_tick);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL missing_hsync_unlock: got %b, required 0", locked);
        end
    endtask

    task automatic test_err_burst();
        int t0;
        t0 = n_terr;
        for (int i = 0; i < 300; i++) begin
            drive_tick(ACT, ACT, 12'h0);
            drive_tick(~ACT, ~ACT, 12'h0);
            drive_tick(ACT, ~ACT, 12'h0);
        end
        checks++;
        if (n_terr - t0 !== 300 || locked !== 1'b0) begin
            errors++;
            $display("FAIL err_burst: got %0d pulses locked=%b, required 300 locked=0", n_terr - t0, locked);
        end
`ifdef VGA_RX_ERRCNT_EN
        checks++;
        if (err_count !== 8'hFF) begin
            errors++;
            $display("FAIL err_count_sat: got %h, required ff", err_count);
        end
`endif
    endtask

    initial begin
        reset          = 1'b0;
        p_tick         = 1'b0;
        hsync          = ~ACT;
        vsync          = ~ACT;
        rgb            = 12'h0;
        model_sig      = 16'h0;
        checks         = 0;
        errors         = 0;
        tick_no        = 0;
        n_pix          = 0;
        n_done         = 0;
        n_terr         = 0;
        last_terr_tick = -1;
        exp_err_tick   = -2;
        last_x         = '0;
        last_y         = '0;
        @(posedge clk); #1;
        test_reset();
        test_lock_pixels();
        test_signature();
        test_short_line();
        test_missing_hsync();
        test_err_burst();
        checks++;
        if (pix_q.size() != 0 || sig_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pixels and %0d signatures pending, required 0", pix_q.size(), sig_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
